// File: rtl/instr_pkg.sv
// Shared formats, opcodes, funct3 codes and writer state for the instruction-store loader.
package instr_pkg;

    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } wr_state_t;

    function automatic logic alu_f3_legal(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) ||
               (f3 == F3_BGE) || (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/instr_mem_writer_if.sv
// Request channel into the loader: decoded instruction fields with valid/ready.
interface instr_mem_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [2:0]  in_funct3;
    logic        in_sub;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [11:0] in_imm;

    modport master (
        output in_valid, in_fmt, in_funct3, in_sub, in_rs1, in_rs2, in_rd, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_funct3, in_sub, in_rs1, in_rs2, in_rd, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encode.sv
// Assembles decoded fields into an RV32I word and flags illegal fmt/funct3 combinations.
// Purely combinational; no handshake.
module instr_encode
    import instr_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic        sub,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [11:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic [6:0] f7;

    always_comb begin
        f7    = (sub && funct3 == F3_ADD) ? F7_SUB : F7_ZERO;
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                legal = alu_f3_legal(funct3);
                word  = {f7, rs2, rs1, funct3, rd, OP_R};
            end
            FMT_I: begin
                legal = alu_f3_legal(funct3);
                word  = {imm, rs1, funct3, rd, OP_I};
            end
            FMT_LOAD: begin
                legal = 1'b1;
                word  = {imm, rs1, F3_WORD, rd, OP_LOAD};
            end
            FMT_STORE: begin
                legal = 1'b1;
                word  = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
            end
            FMT_BRANCH: begin
                // imm arrives pre-split as {b12, b11, b10:5, b4:1}; scatter into B-type slots
                legal = branch_f3_legal(funct3);
                word  = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_writer.sv
// Encodes instruction requests and writes each word little-endian, one byte per cycle.
// Latency: bytes at T+1..T+4 after accept, next accept at T+5; in_ready low while writing or loading the pointer.
module instr_mem_writer
    import instr_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16)
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_mem_writer_if.slave    req,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_in,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 word_done,
    output logic                 err_fmt,
    output logic                 err_range,
    output logic [ADDR_W-1:0]    wr_ptr,
    output logic [31:0]          last_word
);

    // Highest pointer that still leaves room for a full 4-byte word.
    localparam logic [ADDR_W-1:0] PTR_LIMIT = ADDR_W'((1 << ADDR_W) - 4);

    wr_state_t         state, state_n;
    logic [1:0]        k, k_n;
    logic [ADDR_W-1:0] wr_ptr_n;
    logic [31:0]       last_word_n;
    logic              err_fmt_n, err_range_n;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              in_ready_w;
    logic              accept;

    instr_encode u_encode (
        .fmt    (req.in_fmt),
        .funct3 (req.in_funct3),
        .sub    (req.in_sub),
        .rs1    (req.in_rs1),
        .rs2    (req.in_rs2),
        .rd     (req.in_rd),
        .imm    (req.in_imm),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    assign in_ready_w   = (state == ST_IDLE) && !addr_load;
    assign req.in_ready = in_ready_w;
    assign accept       = req.in_valid && in_ready_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= 2'd0;
            wr_ptr    <= BASE_ADDR;
            last_word <= '0;
            err_fmt   <= 1'b0;
            err_range <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            wr_ptr    <= wr_ptr_n;
            last_word <= last_word_n;
            err_fmt   <= err_fmt_n;
            err_range <= err_range_n;
        end
    end

    always_comb begin
        state_n     = state;
        k_n         = k;
        wr_ptr_n    = wr_ptr;
        last_word_n = last_word;
        err_fmt_n   = 1'b0;
        err_range_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (addr_load) begin
                    wr_ptr_n = addr_in;
                end else if (accept) begin
                    if (!enc_legal) begin
                        err_fmt_n = 1'b1;
                    end else if (wr_ptr > PTR_LIMIT) begin
                        err_range_n = 1'b1;
                    end else begin
                        last_word_n = enc_word;
                        state_n     = ST_WRITE;
                        k_n         = 2'd0;
                    end
                end
            end
            ST_WRITE: begin
                if (k == 2'd3) begin
                    state_n  = ST_IDLE;
                    wr_ptr_n = wr_ptr + ADDR_W'(4);
                end else begin
                    k_n = k + 2'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // last_word doubles as the burst buffer, so the byte lanes come straight from it.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        word_done = 1'b0;
        if (state == ST_WRITE) begin
            mem_we    = 1'b1;
            mem_addr  = wr_ptr + ADDR_W'(k);
            mem_wdata = last_word[{k, 3'b000} +: 8];
            word_done = (k == 2'd3);
        end
    end

endmodule

// File: tb/tb_instr_mem_writer.sv
// Scenario bench for instr_mem_writer: expected bytes queued at stimulus, popped by a write monitor.
module tb_instr_mem_writer;
    import instr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        addr_load;
    logic [7:0]  addr_in;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        word_done;
    logic        err_fmt;
    logic        err_range;
    logic [7:0]  wr_ptr;
    logic [31:0] last_word;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb[$];
    wr_t mon_e;

    logic [2:0] alu_f3_tbl [4] = '{3'b000, 3'b111, 3'b110, 3'b100};

    always #5 clk = ~clk;

    instr_mem_writer_if req ();

    instr_mem_writer #(.ADDR_W(8), .BASE_ADDR(8'd16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .word_done (word_done),
        .err_fmt   (err_fmt),
        .err_range (err_range),
        .wr_ptr    (wr_ptr),
        .last_word (last_word)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL mem_write got %h:%h expected %h:%h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic logic [31:0] model_word(input logic [2:0] fmt, input logic [2:0] f3,
                                               input logic sub, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [4:0] rd,
                                               input logic [11:0] imm);
        case (fmt)
            3'd0:    return {((sub && f3 == 3'b000) ? 7'b0100000 : 7'b0000000), rs2, rs1, f3, rd, 7'b0110011};
            3'd1:    return {imm, rs1, f3, rd, 7'b0010011};
            3'd2:    return {imm, rs1, 3'b010, rd, 7'b0000011};
            3'd3:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            default: return {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], 7'b1100011};
        endcase
    endfunction

    task automatic push_word(input logic [7:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) sb.push_back('{base + 8'(i), w[8*i +: 8]});
    endtask

    // Waits (bounded) for in_ready, presents one request for a single accept edge.
    task automatic drive_req(input logic [2:0] fmt, input logic [2:0] f3, input logic sub,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [11:0] imm);
        int n = 0;
        @(negedge clk);
        while (req.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout in_ready=%b expected 1", req.in_ready);
        end
        req.in_fmt = fmt; req.in_funct3 = f3; req.in_sub = sub;
        req.in_rs1 = rs1; req.in_rs2 = rs2; req.in_rd = rd; req.in_imm = imm;
        req.in_valid = 1'b1;
        @(posedge clk);
        #1 req.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (word_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("FAIL done_timeout word_done=%b expected 1", word_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_we, word_done, err_fmt, err_range} !== 4'b0000 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs we/done/ef/er=%b addr=%h data=%h expected 0000/00/00",
                     {mem_we, word_done, err_fmt, err_range}, mem_addr, mem_wdata);
        end
        checks++;
        if (wr_ptr !== 8'd16 || last_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_state wr_ptr=%0d last_word=%h expected 16/00000000", wr_ptr, last_word);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready in_ready=%b expected 1", req.in_ready);
        end
    endtask

    task automatic test_r_add();
        push_word(8'd16, 32'h00428333);
        drive_req(FMT_R, 3'b000, 1'b0, 5'd5, 5'd4, 5'd6, 12'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || req.in_ready !== 1'b0 || word_done !== (i == 4)) begin
                errors++;
                $display("FAIL add_cycle%0d we=%b ready=%b done=%b expected 1/0/%b",
                         i, mem_we, req.in_ready, word_done, (i == 4));
            end
        end
        @(negedge clk);
        checks++;
        if (req.in_ready !== 1'b1 || mem_we !== 1'b0 || wr_ptr !== 8'd20 || last_word !== 32'h00428333) begin
            errors++;
            $display("FAIL add_after ready=%b we=%b wr_ptr=%0d last_word=%h expected 1/0/20/00428333",
                     req.in_ready, mem_we, wr_ptr, last_word);
        end
    endtask

    task automatic test_back_to_back();
        push_word(8'd20, 32'h405404B3);
        push_word(8'd24, 32'h0043A623);
        @(negedge clk);
        req.in_fmt = FMT_R; req.in_funct3 = 3'b000; req.in_sub = 1'b1;
        req.in_rs1 = 5'd8; req.in_rs2 = 5'd5; req.in_rd = 5'd9; req.in_imm = 12'h0;
        req.in_valid = 1'b1;
        @(posedge clk);
        #1;
        req.in_fmt = FMT_STORE; req.in_funct3 = 3'b000; req.in_sub = 1'b0;
        req.in_rs1 = 5'd7; req.in_rs2 = 5'd4; req.in_rd = 5'd0; req.in_imm = 12'h00C;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (req.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy_cycle%0d in_ready=%b expected 0", i, req.in_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (req.in_ready !== 1'b1 || mem_we !== 1'b0 || last_word !== 32'h405404B3) begin
            errors++;
            $display("FAIL b2b_t5 ready=%b we=%b last_word=%h expected 1/0/405404B3",
                     req.in_ready, mem_we, last_word);
        end
        @(posedge clk);
        #1 req.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd24) begin
            errors++;
            $display("FAIL b2b_second_start we=%b addr=%0d expected 1/24", mem_we, mem_addr);
        end
        wait_done();
        @(negedge clk);
        checks++;
        if (last_word !== 32'h0043A623 || wr_ptr !== 8'd28) begin
            errors++;
            $display("FAIL store_word last_word=%h wr_ptr=%0d expected 0043A623/28", last_word, wr_ptr);
        end
        checks++;
        if (last_word[24:20] !== 5'd4 || last_word[19:15] !== 5'd7 ||
            {last_word[31:25], last_word[11:7]} !== 12'h00C || last_word[6:0] !== OP_STORE) begin
            errors++;
            $display("FAIL store_decode rs2=%0d rs1=%0d imm=%h expected 4/7/00c",
                     last_word[24:20], last_word[19:15], {last_word[31:25], last_word[11:7]});
        end
    endtask

    task automatic test_branch();
        push_word(8'd28, 32'h2AC30163);
        drive_req(FMT_BRANCH, 3'b000, 1'b0, 5'd6, 5'd12, 5'd0, 12'h151);
        @(negedge clk);
        wait_done();
        @(negedge clk);
        checks++;
        if (last_word !== 32'h2AC30163 || wr_ptr !== 8'd32) begin
            errors++;
            $display("FAIL branch_word last_word=%h wr_ptr=%0d expected 2AC30163/32", last_word, wr_ptr);
        end
        checks++;
        if ({last_word[31], last_word[7], last_word[30:25], last_word[11:8]} !== 12'h151 ||
            last_word[24:20] !== 5'd12 || last_word[19:15] !== 5'd6 || last_word[14:12] !== 3'b000) begin
            errors++;
            $display("FAIL branch_decode imm=%h rs2=%0d rs1=%0d expected 151/12/6",
                     {last_word[31], last_word[7], last_word[30:25], last_word[11:8]},
                     last_word[24:20], last_word[19:15]);
        end
    endtask

    task automatic test_err_fmt();
        logic [2:0] fmts [2] = '{3'd5, FMT_R};
        logic [2:0] f3s  [2] = '{3'b000, 3'b001};
        for (int i = 0; i < 2; i++) begin
            drive_req(fmts[i], f3s[i], 1'b0, 5'd1, 5'd2, 5'd3, 12'h0);
            @(negedge clk);
            checks++;
            if (err_fmt !== 1'b1 || err_range !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL err_fmt_pulse%0d ef=%b er=%b we=%b expected 1/0/0", i, err_fmt, err_range, mem_we);
            end
            @(negedge clk);
            checks++;
            if (err_fmt !== 1'b0 || wr_ptr !== 8'd32 || req.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL err_fmt_after%0d ef=%b wr_ptr=%0d ready=%b expected 0/32/1",
                         i, err_fmt, wr_ptr, req.in_ready);
            end
        end
    endtask

    task automatic test_err_range();
        @(negedge clk);
        addr_load = 1'b1;
        addr_in   = 8'd253;
        #1;
        checks++;
        if (req.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_blocks_ready in_ready=%b expected 0", req.in_ready);
        end
        @(posedge clk);
        #1 addr_load = 1'b0;
        drive_req(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd2, 12'h005);
        @(negedge clk);
        checks++;
        if (err_range !== 1'b1 || err_fmt !== 1'b0 || mem_we !== 1'b0 || wr_ptr !== 8'd253) begin
            errors++;
            $display("FAIL err_range_pulse er=%b ef=%b we=%b wr_ptr=%0d expected 1/0/0/253",
                     err_range, err_fmt, mem_we, wr_ptr);
        end
        drive_req(3'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd2, 12'h005);
        @(negedge clk);
        checks++;
        if (err_fmt !== 1'b1 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL err_priority ef=%b er=%b expected 1/0", err_fmt, err_range);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        // addr_load and in_valid together: the load must win and nothing is accepted
        @(negedge clk);
        addr_load = 1'b1; addr_in = 8'd252;
        req.in_fmt = FMT_I; req.in_funct3 = 3'b000; req.in_valid = 1'b1;
        @(posedge clk);
        #1 begin addr_load = 1'b0; req.in_valid = 1'b0; end
        @(negedge clk);
        checks++;
        if (wr_ptr !== 8'd252 || mem_we !== 1'b0 || err_fmt !== 1'b0 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL load_wins wr_ptr=%0d we=%b ef=%b er=%b expected 252/0/0/0",
                     wr_ptr, mem_we, err_fmt, err_range);
        end
        w = model_word(FMT_LOAD, 3'b000, 1'b0, 5'd2, 5'd0, 5'd1, 12'h7FF);
        push_word(8'd252, w);
        drive_req(FMT_LOAD, 3'b000, 1'b0, 5'd2, 5'd0, 5'd1, 12'h7FF);
        @(negedge clk);
        wait_done();
        @(negedge clk);
        checks++;
        if (wr_ptr !== 8'd0 || last_word !== w) begin
            errors++;
            $display("FAIL wrap wr_ptr=%0d last_word=%h expected 0/%h", wr_ptr, last_word, w);
        end
    endtask

    task automatic test_random_i();
        logic [31:0] w;
        logic [2:0]  f3;
        logic [4:0]  rs1, rd;
        logic [11:0] imm;
        for (int i = 0; i < 6; i++) begin
            f3  = alu_f3_tbl[$urandom_range(0, 3)];
            rs1 = 5'($urandom);
            rd  = 5'($urandom);
            imm = 12'($urandom);
            w   = model_word(FMT_I, f3, 1'b0, rs1, 5'd0, rd, imm);
            push_word(8'(4 * i), w);
            drive_req(FMT_I, f3, 1'b1, rs1, 5'($urandom), rd, imm);
            @(negedge clk);
            wait_done();
            @(negedge clk);
            checks++;
            if (last_word !== w || wr_ptr !== 8'(4 * i + 4)) begin
                errors++;
                $display("FAIL rand_i%0d last_word=%h wr_ptr=%0d expected %h/%0d",
                         i, last_word, wr_ptr, w, 4 * i + 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        sb.push_back('{8'd24, 8'h33});
        sb.push_back('{8'd25, 8'h83});
        drive_req(FMT_R, 3'b000, 1'b0, 5'd5, 5'd4, 5'd6, 12'h0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || wr_ptr !== 8'd16 || word_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid we=%b wr_ptr=%0d done=%b expected 0/16/0", mem_we, wr_ptr, word_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req.in_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready ready=%b we=%b expected 1/0", req.in_ready, mem_we);
        end
    endtask

    initial begin
        req.in_valid = 1'b0; req.in_fmt = '0; req.in_funct3 = '0; req.in_sub = 1'b0;
        req.in_rs1 = '0; req.in_rs2 = '0; req.in_rd = '0; req.in_imm = '0;
        addr_load = 1'b0;
        addr_in   = '0;
        test_reset();
        test_r_add();
        test_back_to_back();
        test_branch();
        test_err_fmt();
        test_err_range();
        test_wrap();
        test_random_i();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_writer.md
Name: instr_mem_writer

Overview:
- Encoder/loader for the instruction store. It accepts decoded-field instruction requests (format, funct3, sub flag, rs1, rs2, rd, imm) over a valid/ready handshake.
- Each request is assembled into a 32-bit RV32I word. The word is written little-endian, one byte per cycle, into the 256-byte instruction memory through a byte write port.
- It is the writer-side inverse of the fetch/decode path. The imm packing matches the decode path exactly, so decoding a written word returns the original fields.

Parameters:
- ADDR_W, 8, byte address width of instruction memory.
- BASE_ADDR, 16, write-pointer value after reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted this cycle.
- in_fmt  in  3  format: R=0, I=1, LOAD=2, STORE=3, BRANCH=4; others illegal.
- in_funct3  in  3  funct3 for R/I/BRANCH; ignored for LOAD/STORE (forced 010).
- in_sub  in  1  R-type only: when funct3=000, 1 selects SUB.
- in_rs1, in_rs2, in_rd  in  5 each  register fields.
- in_imm  in  12  I/LOAD/STORE: imm[11:0]; BRANCH: {imm12, imm11, imm[10:5], imm[4:1]}.
- addr_load  in  1  load write pointer from addr_in.
- addr_in  in  ADDR_W  new write pointer value.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- word_done  out  1  one-cycle pulse on the cycle of the last byte write.
- err_fmt  out  1  one-cycle pulse: illegal fmt/funct3; request dropped.
- err_range  out  1  one-cycle pulse: pointer > 252 at accept; request dropped.
- wr_ptr  out  ADDR_W  current write pointer.
- last_word  out  32  most recently assembled legal word.

Behaviour:
- Reset values:
  - State IDLE; wr_ptr = BASE_ADDR; last_word = 0.
  - mem_we, word_done, err_fmt, err_range = 0; mem_addr = 0; mem_wdata = 0.
  - in_ready = 1 in the cycle after rst deasserts.
- Reset mid-write: the burst aborts, mem_we = 0 from the next cycle, and wr_ptr returns to BASE_ADDR. Bytes already written are not reverted.
- States:
  - IDLE: in_ready = !addr_load.
  - WRITE: byte counter k = 0..3; in_ready = 0.
- addr_load in IDLE: wr_ptr <= addr_in and no accept that cycle (load wins over in_valid). addr_load in WRITE is ignored.
- Accept = in_valid & in_ready at cycle T. At T the module does one of three things:
  - Illegal fmt/funct3: pulse err_fmt at T+1; stay IDLE.
  - Else if wr_ptr > 252: pulse err_range at T+1; stay IDLE. The illegal check takes priority.
  - Else: register the word into last_word; go to WRITE, k=0.
- WRITE, cycle T+1+k:
  - mem_we = 1, mem_addr = wr_ptr + k, mem_wdata = word[8k+7:8k].
  - At k=3: word_done = 1, wr_ptr <= wr_ptr + 4 (mod 2^ADDR_W; 252 wraps to 0), next state IDLE.
- Throughput: in_ready is high again at T+5, giving one word per 5 cycles.
- Legal funct3:
  - R and I: 000, 111, 110, 100.
  - BRANCH: 000, 001, 100, 101, 110, 111.
- Encoding (msb..lsb):
  - R: {f7, rs2, rs1, funct3, rd, 0110011}; f7 = 0100000 if in_sub & funct3==000, else 0000000. in_sub is ignored for other funct3.
  - I: {imm[11:0], rs1, funct3, rd, 0010011}.
  - LOAD: {imm[11:0], rs1, 010, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BRANCH: {in_imm[11], in_imm[9:4], rs2, rs1, funct3, in_imm[3:0], in_imm[10], 1100011}.
- Unused register fields are not encoded (e.g. rs2 for I, rd for STORE/BRANCH).

Decomposition:
- Package instr_pkg:
  - Format codes FMT_R..FMT_BRANCH.
  - Opcode constants OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - funct3 constants, F7_SUB.
- Sub-module instr_encode: purely combinational fields -> {word, legal}. The sequential byte writer stays in instr_mem_writer.

Test Plan:
- Reset, then R add rd=6, rs1=5, rs2=4, f3=000 -> mem writes 16:0x33, 17:0x83, 18:0x42, 19:0x00 at T+1..T+4; word_done at T+4; wr_ptr=20; last_word=0x00428333.
- R sub rd=9, rs1=8, rs2=5 -> bytes 0xB3, 0x04, 0x54, 0x40 at 20..23; in_ready low T..T+4; back-to-back request accepted at T+5.
- STORE rs1=7, rs2=4, imm=0x00C, then BRANCH f3=000, rs1=6, rs2=12, in_imm=0x151:
  - STORE -> word 0x0043A623, bytes 23 A6 43 00.
  - BRANCH -> word 0x2AC30163, bytes 63 01 C3 2A.
  - Both words decode back to the original fields.
- in_fmt=5, or R with f3=001 -> err_fmt pulse at T+1, no mem_we, wr_ptr unchanged. addr_load=1 with addr_in=253, then a legal request -> err_range pulse, no writes.
- addr_load with addr_in=252, then a legal request -> writes at 252..255, wr_ptr=0.
- rst asserted at k=1 -> mem_we=0 next cycle, wr_ptr=16, in_ready=1 after rst deasserts.
